// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the radix-2 SDF FFT pipeline.
// Accepts frames of 2^N complex samples in bit-reversed arrival order and
// re-emits them in natural frequency order through a ping-pong pair of banks.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_in, in_valid  first-sample marker and sample strobe
//   in_re, in_im        signed input sample
//   out_valid/out_start registered output strobe and frame-start marker
//   out_idx             natural frequency index of the output sample
//   out_re, out_im      registered output sample
//   busy                any bank filling, full or draining
module fft_out_reorder #(
    parameter int unsigned N      = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic              out_start,
    output logic [N-1:0]      out_idx,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              busy
);

    localparam int unsigned DEPTH     = 1 << N;
    localparam int unsigned AW        = N + 1;
    localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

    typedef enum logic {W_IDLE, W_FILL}  wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int unsigned i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    logic [DATA_W-1:0] r_mem_re [0:2*DEPTH-1];
    logic [DATA_W-1:0] r_mem_im [0:2*DEPTH-1];

    wstate_t      r_wstate, w_wstate_nxt;
    rstate_t      r_rstate, w_rstate_nxt;
    logic [N-1:0] r_wcnt, w_wcnt_nxt;
    logic [N-1:0] r_rcnt, w_rcnt_nxt;
    logic         r_wbank, w_wbank_nxt;
    logic         r_rbank, w_rbank_nxt;
    logic [1:0]   r_full, w_full_nxt;

    logic          w_wr_en;
    logic [N-1:0]  w_wr_addr;
    logic          w_set_full;
    logic          w_rd_en;
    logic          w_clr_full;
    logic [AW-1:0] w_rd_addr;
    logic          w_busy_nxt;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Write FSM: fill the current write bank; a new start restarts at address 0
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_wbank_nxt  = r_wbank;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_set_full   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (in_valid && start_in) begin
                    w_wr_en      = 1'b1;
                    w_wcnt_nxt   = N'(1);
                    w_wstate_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (start_in) begin
                        w_wcnt_nxt = N'(1);
                    end else begin
                        w_wr_addr = r_wcnt;
                        if (r_wcnt == LAST_ADDR) begin
                            w_set_full   = 1'b1;
                            w_wbank_nxt  = ~r_wbank;
                            w_wcnt_nxt   = '0;
                            w_wstate_nxt = W_IDLE;
                        end else begin
                            w_wcnt_nxt = r_wcnt + N'(1);
                        end
                    end
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read FSM: drain a full bank in natural order; chain straight into the other bank if ready
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        w_rbank_nxt  = r_rbank;
        w_rd_en      = 1'b0;
        w_clr_full   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_rcnt_nxt   = '0;
                    w_rstate_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                w_rd_en = 1'b1;
                if (r_rcnt == LAST_ADDR) begin
                    w_clr_full  = 1'b1;
                    w_rbank_nxt = ~r_rbank;
                    w_rcnt_nxt  = '0;
                    if (!r_full[~r_rbank]) w_rstate_nxt = R_IDLE;
                end else begin
                    w_rcnt_nxt = r_rcnt + N'(1);
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Full flags: drain clears, fill sets; they never target the same bank on one edge
    always_comb begin
        w_full_nxt = r_full;
        if (w_clr_full) w_full_nxt[r_rbank] = 1'b0;
        if (w_set_full) w_full_nxt[r_wbank] = 1'b1;
    end

    assign w_rd_addr  = {r_rbank, bitrev(r_rcnt)};
    // busy is registered from next-state values so it matches the live state
    assign w_busy_nxt = (w_wstate_nxt == W_FILL) | (|w_full_nxt)
                      | (w_rstate_nxt == R_DRAIN) | w_rd_en;

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_wbank   <= 1'b0;
            r_rbank   <= 1'b0;
            r_full    <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_idx   <= '0;
            out_re    <= '0;
            out_im    <= '0;
            busy      <= 1'b0;
        end else begin
            r_wcnt    <= w_wcnt_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_wbank   <= w_wbank_nxt;
            r_rbank   <= w_rbank_nxt;
            r_full    <= w_full_nxt;
            busy      <= w_busy_nxt;
            out_valid <= w_rd_en;
            out_start <= w_rd_en && (r_rcnt == '0);
            if (w_rd_en) begin
                out_idx <= r_rcnt;
                out_re  <= r_mem_re[w_rd_addr];
                out_im  <= r_mem_im[w_rd_addr];
            end
        end
    end

    // Sample memory; the read above sees pre-edge contents (read-before-write)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_re[{r_wbank, w_wr_addr}] <= in_re;
            r_mem_im[{r_wbank, w_wr_addr}] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder (N=3, DATA_W=16).
module tb_fft_out_reorder;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_in, in_valid;
    logic [DW-1:0] in_re, in_im;
    logic          out_valid, out_start, busy;
    logic [N-1:0]  out_idx;
    logic [DW-1:0] out_re, out_im;

    fft_out_reorder #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_start(out_start),
        .out_idx(out_idx), .out_re(out_re), .out_im(out_im), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [N-1:0]  idx;
        logic          st;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_start = 0;

    // Natural index k holds arrival index REV[k]
    int unsigned REV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [DW-1:0] m_re [8];
    logic [DW-1:0] m_im [8];
    int            m_cnt = 0;
    bit            m_in  = 0;
    int            m_last_end = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the natural-order frame; output can't start before E+2 or before the previous frame ends
    task automatic push_frame(input int e);
        exp_t x;
        int   base;
        base = (e + 2 > m_last_end + 1) ? e + 2 : m_last_end + 1;
        for (int k = 0; k < 8; k++) begin
            x.re  = m_re[REV[k]];
            x.im  = m_im[REV[k]];
            x.idx = N'(k);
            x.st  = (k == 0);
            x.cyc = base + k;
            sb.push_back(x);
        end
        m_last_end = base + 7;
    endtask

    // Drive one cycle of input (called at posedge+1) and update the reference model
    task automatic drive(input logic st, input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        start_in = st;
        in_valid = v;
        in_re    = re;
        in_im    = im;
        @(posedge clk);
        #1;
        if (v) begin
            if (st) begin
                m_cnt = 0;
                m_in  = 1;
            end
            if (m_in) begin
                m_re[m_cnt] = re;
                m_im[m_cnt] = im;
                m_cnt++;
                if (m_cnt == 8) begin
                    push_frame(cyc);
                    m_in = 0;
                end
            end
        end
        start_in = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1'b1, DW'(base + i), DW'(-(base + i)));
            if (gap && i < 7) drive(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        idle(2);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
    endtask

    // Output monitor: every out_valid must match the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid) begin
            n_out++;
            if (out_start) n_start++;
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(out_re), 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_re", 64'(out_re), 64'(e.re));
                chk("out_im", 64'(out_im), 64'(e.im));
                chk("out_idx", 64'(out_idx), 64'(e.idx));
                chk("out_start", 64'(out_start), 64'(e.st));
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (rst_n && out_start) begin
            chk("start_without_valid", 64'(out_start), 64'd0);
        end
    end

    initial begin : stim
        int s0;
        rst_n    = 1'b0;
        start_in = 1'b0;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_start", 64'(out_start), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_re", 64'(out_re), 64'd0);
        chk("rst_im", 64'(out_im), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Single contiguous frame
        drive(1'b1, 1'b1, DW'(0), DW'(0));
        chk("fill_busy", 64'(busy), 64'd1);
        for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, DW'(i), DW'(-i));
        wait_drain();

        // Two back-to-back frames: 16 consecutive outputs, two start pulses
        s0 = n_start;
        send_frame(0, 1'b0);
        send_frame(8, 1'b0);
        wait_drain();
        chk("b2b_starts", 64'(n_start - s0), 64'd2);

        // Restart: partial frame 100..104 must be discarded
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, DW'(100 + i), DW'(-(100 + i)));
        send_frame(0, 1'b0);
        wait_drain();

        // Gapped input
        send_frame(0, 1'b1);
        wait_drain();

        // Reset in the middle of a drain
        s0 = n_out;
        send_frame(0, 1'b0);
        for (int i = 0; i < 50 && n_out < s0 + 3; i++) idle(1);
        chk("pre_reset_outs", 64'(n_out >= s0 + 3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_re", 64'(out_re), 64'd0);
        chk("mid_rst_im", 64'(out_im), 64'd0);
        chk("mid_rst_idx", 64'(out_idx), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        m_in       = 0;
        m_last_end = 0;
        idle(2);
        rst_n = 1'b1;
        s0 = n_out;
        idle(15);
        chk("post_rst_silent", 64'(n_out - s0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        send_frame(40, 1'b0);
        wait_drain();

        // Idle noise: in_valid without start_in
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)));
            chk("noise_valid", 64'(out_valid), 64'd0);
            chk("noise_busy", 64'(busy), 64'd0);
        end
        idle(5);
        chk("noise_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output-side consumer of the radix-2 SDF FFT pipeline; sits after the last bf_stage.
- Receives each frame of 2^N complex samples serially, in the pipeline's bit-reversed order, and re-emits them in natural frequency order.
- Ping-pong buffer: two banks of 2^N words, so back-to-back frames stream continuously. Synthesizable fixed-point.

Parameters:
N, 3, log2 of FFT length; frame = 2^N samples
DATA_W, 16, signed width of each real/imag component

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_in  input  1  high with the first sample of a frame (mirrors stage start_op)
in_valid  input  1  sample present on in_re/in_im this cycle
in_re  input  DATA_W  real part, signed
in_im  input  DATA_W  imaginary part, signed
out_valid  output  1  out_re/out_im hold a valid sample
out_start  output  1  high with natural-index-0 sample of each output frame
out_idx  output  N  natural frequency index of current output sample
out_re  output  DATA_W  real part, registered
out_im  output  DATA_W  imaginary part, registered
busy  output  1  any bank filling, full or draining

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_start=0, out_idx=0, out_re=0, out_im=0, busy=0; write/read counters=0; both bank-full flags clear; write bank select=0; write FSM W_IDLE, read FSM R_IDLE. Memory contents not cleared, never observable.
- Write FSM: W_IDLE -> W_FILL on (in_valid & start_in); that sample written to addr 0 of the write bank, wcnt=1.
- W_FILL: each in_valid writes addr wcnt, wcnt++. Gaps (in_valid=0) allowed, no effect.
- When addr 2^N-1 is written: set full flag of that bank, toggle write bank, go to W_IDLE.
- start_in & in_valid while in W_FILL: partial frame discarded (full flag not set); sample taken as addr 0 of the same bank, wcnt=1.
- in_valid without start_in in W_IDLE: ignored.
- Address i in a bank holds arrival index i; arrival index = bitrev_N(natural index).
- Read FSM: R_IDLE -> R_DRAIN when the read bank's full flag is set. R_DRAIN issues one read per cycle, rcnt = 0..2^N-1, address bitrev_N(rcnt).
- Output registered one cycle after read issue: out_idx=rcnt, out_valid=1, out_start=(rcnt==0).
- After rcnt=2^N-1 issued: clear that bank's full flag on the same edge, toggle read bank. If the other bank is full, continue in R_DRAIN with rcnt=0 (no bubble); else R_IDLE.
- out_valid=0: out_re/out_im/out_idx hold last value, out_start=0.
- Latency: last sample of a frame sampled at edge E -> natural index 0 output valid after edge E+2; index k after edge E+2+k.
- Bank reuse: a bank is writable on the edge its full flag clears. Memory is read-before-write, so a same-edge write cannot corrupt the final read.
- Overflow is impossible: input ≤1 sample/cycle and output is never stalled. Writes to a full bank need no check.
- No backpressure; the downstream consumer must accept every out_valid cycle.
- busy = (write FSM in W_FILL) | either full flag | (read FSM in R_DRAIN) | out_valid.
- Arithmetic: none. Data passes bit-exact.

Test Plan:
- N=3, one frame, in_re=arrival index 0..7, in_im=-index, contiguous, start_in on first -> out_re sequence 0,4,2,6,1,5,3,7 with out_im negated. out_idx 0..7. out_start only on first. First out_valid 2 edges after last input.
- Two back-to-back frames (second re=8..15) -> 16 consecutive out_valid cycles with no gap. Second frame yields 8,12,10,14,9,13,11,15. out_start pulses exactly twice, 8 cycles apart.
- Restart: start_in, 5 samples (values 100..104), then start_in with a full frame 0..7 -> output only 0,4,2,6,1,5,3,7; no 100..104 value ever appears.
- Gapped input: frame 0..7 with in_valid low every other cycle -> same natural-order output, contiguous 8-cycle burst starting 2 edges after last sample.
- Reset mid-drain: assert rst_n low after 3 outputs -> outputs zero immediately (async). After release, nothing is output until a new start_in frame. A new frame then reorders correctly.
- Idle noise: in_valid pulses without start_in while idle -> out_valid stays 0, busy stays 0.
